// File: rtl/irq_controller_if.sv
// CPU IO-bus bundle for the interrupt controller: address, write data, strobes and
// OR-mergeable read data.
interface irq_controller_if;
    logic [15:0] io_addr;
    logic [7:0]  io_din;
    logic        io_write_en;
    logic        io_read_en;
    logic [7:0]  io_dout;

    modport master (
        output io_addr,
        output io_din,
        output io_write_en,
        output io_read_en,
        input  io_dout
    );

    modport slave (
        input  io_addr,
        input  io_din,
        input  io_write_en,
        input  io_read_en,
        output io_dout
    );
endinterface

// File: rtl/irq_controller.sv
// Four-line interrupt controller with PEND/EN/CFG/SWTRIG registers on the IO bus.
// Optional macro IRQ_SYNC_EN inserts a 2-flop synchronizer on the raw sources.
module irq_controller #(
    parameter logic [15:0] BASE_ADDR = 16'h1080
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       src,
    input  logic [3:0]       irq_clr,
    output logic [3:0]       irq_out,
    irq_controller_if.slave  bus
);

    logic [3:0]  pend_reg;
    logic [3:0]  en_reg;
    logic [7:0]  cfg_reg;
    logic [3:0]  prev_reg;
    logic [3:0]  irq_reg;
    logic [7:0]  dout_reg;

    logic [3:0]  s;
    logic [3:0]  q;
    logic [3:0]  hw_set;
    logic [3:0]  sw_set;
    logic [3:0]  clr;
    logic [3:0]  pend_next;
    logic [7:0]  rd_data;
    logic [15:0] offset;
    logic [1:0]  sel;
    logic        hit;
    logic        wr;
    logic        rd;

    // Unsigned subtraction makes addresses below BASE_ADDR wrap high and miss.
    assign offset = bus.io_addr - BASE_ADDR;
    assign hit    = (offset < 16'd4);
    assign sel    = offset[1:0];
    assign wr     = bus.io_write_en & hit;
    assign rd     = bus.io_read_en & hit;

`ifdef IRQ_SYNC_EN
    logic [3:0] sync1_reg;
    logic [3:0] sync2_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg <= 4'd0;
            sync2_reg <= 4'd0;
        end else begin
            sync1_reg <= src;
            sync2_reg <= sync1_reg;
        end
    end

    assign s = sync2_reg;
`else
    assign s = src;
`endif

    assign q = s ^ cfg_reg[7:4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_line
            assign hw_set[gi] = cfg_reg[gi] ? (q[gi] & ~prev_reg[gi]) : q[gi];
        end
    endgenerate

    assign sw_set = (wr && sel == 2'd3) ? bus.io_din[3:0] : 4'd0;
    assign clr    = irq_clr | ((wr && sel == 2'd0) ? bus.io_din[3:0] : 4'd0);

    // Sets are OR'd after the clear so a coincident set always survives.
    assign pend_next = (pend_reg & ~clr) | hw_set | sw_set;

    always_comb begin
        rd_data = 8'd0;
        case (sel)
            2'd0:    rd_data = {4'd0, pend_reg};
            2'd1:    rd_data = {4'd0, en_reg};
            2'd2:    rd_data = cfg_reg;
            default: rd_data = 8'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_reg <= 4'd0;
            en_reg   <= 4'd0;
            cfg_reg  <= 8'd0;
            prev_reg <= 4'd0;
            irq_reg  <= 4'd0;
            dout_reg <= 8'd0;
        end else begin
            prev_reg <= q;
            pend_reg <= pend_next;
            if (wr && sel == 2'd1) begin
                en_reg <= bus.io_din[3:0];
            end
            if (wr && sel == 2'd2) begin
                cfg_reg <= bus.io_din;
            end
            irq_reg  <= pend_reg & en_reg;
            dout_reg <= rd ? rd_data : 8'd0;
        end
    end

    assign irq_out     = irq_reg;
    assign bus.io_dout = dout_reg;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: expected values go through a scoreboard queue
// and are checked with immediate assertions when the DUT output is due.
module tb_irq_controller;

    localparam logic [15:0] BASE = 16'h1080;
`ifdef IRQ_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] src;
    logic [3:0] irq_clr;
    logic [3:0] irq_out;

    irq_controller_if bus ();

    irq_controller #(.BASE_ADDR(BASE)) dut (
        .clk     (clk),
        .reset   (reset),
        .src     (src),
        .irq_clr (irq_clr),
        .irq_out (irq_out),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] sb[$];

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] observed);
        logic [7:0] expected;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL %s observed=%h expected=<empty scoreboard>", tag, observed);
        end else begin
            expected = sb.pop_front();
            assert (observed === expected) else begin
                miscompares++;
                $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
            end
        end
        $display("vector %0d %s observed=%h", vectors, tag, observed);
    endtask

    task automatic check_irq(input string tag, input logic [3:0] exp_irq);
        sb.push_back({4'd0, exp_irq});
        check(tag, {4'd0, irq_out});
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        bus.io_addr     = a;
        bus.io_din      = d;
        bus.io_write_en = 1'b1;
        tick();
        bus.io_write_en = 1'b0;
    endtask

    task automatic bus_read(input string tag, input logic [15:0] a, input logic [7:0] exp_d);
        bus.io_addr    = a;
        bus.io_read_en = 1'b1;
        sb.push_back(exp_d);
        tick();
        bus.io_read_en = 1'b0;
        check(tag, bus.io_dout);
    endtask

    initial begin
        reset           = 1'b1;
        src             = 4'd0;
        irq_clr         = 4'd0;
        bus.io_addr     = 16'd0;
        bus.io_din      = 8'd0;
        bus.io_write_en = 1'b0;
        bus.io_read_en  = 1'b0;
        #12;
        check_irq("reset_irq", 4'd0);
        sb.push_back(8'd0);
        check("reset_dout", bus.io_dout);
        tick();
        reset = 1'b0;
        tick();

        // Edge mode on line 0
        bus_write(BASE + 16'd2, 8'h0F);
        bus_write(BASE + 16'd1, 8'h01);
        src = 4'b0001;
        tick();
        src = 4'b0000;
        repeat (LAT - 1) tick();
        bus_read("edge_pend", BASE, 8'h01);
        check_irq("edge_irq", 4'b0001);
        tick();
        sb.push_back(8'h00);
        check("dout_returns_zero", bus.io_dout);
        irq_clr = 4'b0001;
        tick();
        irq_clr = 4'b0000;
        tick();
        check_irq("edge_clr_irq", 4'b0000);
        bus_read("edge_clr_pend", BASE, 8'h00);

        // Level mode on line 1: clears ignored while source active
        bus_write(BASE + 16'd2, 8'h00);
        bus_write(BASE + 16'd1, 8'h02);
        src = 4'b0010;
        repeat (LAT) tick();
        irq_clr = 4'b0010;
        bus_write(BASE, 8'h02);
        irq_clr = 4'b0000;
        check_irq("level_irq", 4'b0010);
        bus_read("level_hold_pend", BASE, 8'h02);
        src = 4'b0000;
        repeat (LAT + 1) tick();
        bus_write(BASE, 8'h02);
        bus_read("level_clr_pend", BASE, 8'h00);

        // Inverted level on line 3
        bus_write(BASE + 16'd2, 8'h84);
        bus_write(BASE + 16'd1, 8'h08);
        tick();
        tick();
        check_irq("polarity_irq_on", 4'b1000);
        src = 4'b1000;
        repeat (LAT) tick();
        bus_write(BASE, 8'h08);
        tick();
        check_irq("polarity_irq_off", 4'b0000);
        bus_read("polarity_pend", BASE, 8'h00);

        // Collision of edge set with irq_clr on line 2
        src = 4'b0000;
        repeat (LAT + 1) tick();
        bus_write(BASE + 16'd2, 8'h04);
        bus_write(BASE, 8'h0F);
        bus_read("collision_clean", BASE, 8'h00);
        src = 4'b0100;
        repeat (LAT - 1) tick();
        irq_clr = 4'b0100;
        tick();
        irq_clr = 4'b0000;
        src = 4'b0000;
        bus_read("collision_pend", BASE, 8'h04);
        irq_clr = 4'b0100;
        tick();
        irq_clr = 4'b0000;
        bus_read("collision_cleared", BASE, 8'h00);

        // Bus decode, SWTRIG, out-of-range accesses, read-during-write
        bus_write(BASE + 16'd1, 8'h00);
        bus_write(BASE + 16'd3, 8'h05);
        bus_read("swtrig_pend", BASE, 8'h05);
        check_irq("swtrig_irq_masked", 4'b0000);
        bus_read("oob_read", BASE + 16'd4, 8'h00);
        bus_read("swtrig_reads_zero", BASE + 16'd3, 8'h00);
        bus_read("cfg_read", BASE + 16'd2, 8'h04);
        bus_write(BASE + 16'd5, 8'hFF);
        bus_write(BASE - 16'd1, 8'hFF);
        bus_read("oob_write_en", BASE + 16'd1, 8'h00);
        bus_read("oob_write_cfg", BASE + 16'd2, 8'h04);
        bus.io_addr     = BASE + 16'd1;
        bus.io_din      = 8'h0A;
        bus.io_write_en = 1'b1;
        bus.io_read_en  = 1'b1;
        sb.push_back(8'h00);
        tick();
        bus.io_write_en = 1'b0;
        bus.io_read_en  = 1'b0;
        check("rdw_old_value", bus.io_dout);
        bus_read("rdw_new_value", BASE + 16'd1, 8'h0A);

        // Asynchronous reset between edges
        bus_write(BASE, 8'h0F);
        bus_write(BASE + 16'd3, 8'h0F);
        bus_write(BASE + 16'd1, 8'h0F);
        tick();
        check_irq("pre_reset_irq", 4'hF);
        bus_read("pre_reset_pend", BASE, 8'h0F);
        bus_read("pre_reset_dout_hold", BASE, 8'h0F);
        #2;
        reset = 1'b1;
        #1;
        check_irq("async_reset_irq", 4'd0);
        sb.push_back(8'h00);
        check("async_reset_dout", bus.io_dout);
        tick();
        reset = 1'b0;
        bus_read("post_reset_pend", BASE, 8'h00);
        bus_read("post_reset_en", BASE + 16'd1, 8'h00);
        bus_read("post_reset_cfg", BASE + 16'd2, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
